// File: rtl/acelp_codebook_sequencer_if.sv
// ---------------------------------------------------------------------------
// acelp_codebook_sequencer_if
//
// Purpose: bundles every non-clock signal of the ACELP fixed-codebook
// sequencer. This covers the run request, the test memory port, the three
// stage ports, the muxed scratch-memory port and the status outputs.
//
// Modports:
//   master - the environment side (test logic and the three datapath stages).
//            It drives start, testMuxSel, the test port and the sN* stage
//            signals. It observes the start pulses, the muxed memory port
//            and the status outputs.
//   slave  - the sequencer itself (directions mirrored).
//
// Signals (ADDR_W / DATA_W wide where noted):
//   start, testMuxSel                     run request / test-port select
//   testReadAddr, testWriteAddr [ADDR_W]  test-port addresses
//   testMemOut [DATA_W], testMemWriteEn   test-port write data / enable
//   sNDone, sNReadAddr, sNWriteAddr,
//   sNMemOut, sNWriteEn (N=0..2)          stage handshake and memory requests
//   sNStart (N=0..2)                      one-cycle start pulse per stage
//   memReadAddr, memWriteAddr, memOut,
//   memWriteEn                            muxed scratch-memory port
//   busy, done, timeoutErr, failedStage   run status
//   lastRunCycles [16]                    busy-cycle count of the last run
//   dbgState, dbgStage                    FSM state / active stage (debug)
//
// Handshake: a stage is started by a single-cycle sNStart pulse. The stage
// answers by raising its sNDone level. The sequencer only looks at sNDone
// of the active stage, and only in the cycles after the pulse.
// ---------------------------------------------------------------------------
interface acelp_codebook_sequencer_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
);
    logic              start;
    logic              testMuxSel;
    logic [ADDR_W-1:0] testReadAddr;
    logic [ADDR_W-1:0] testWriteAddr;
    logic [DATA_W-1:0] testMemOut;
    logic              testMemWriteEn;

    logic              s0Done, s1Done, s2Done;
    logic [ADDR_W-1:0] s0ReadAddr, s1ReadAddr, s2ReadAddr;
    logic [ADDR_W-1:0] s0WriteAddr, s1WriteAddr, s2WriteAddr;
    logic [DATA_W-1:0] s0MemOut, s1MemOut, s2MemOut;
    logic              s0WriteEn, s1WriteEn, s2WriteEn;
    logic              s0Start, s1Start, s2Start;

    logic [ADDR_W-1:0] memReadAddr;
    logic [ADDR_W-1:0] memWriteAddr;
    logic [DATA_W-1:0] memOut;
    logic              memWriteEn;
    logic              busy;
    logic              done;
    logic              timeoutErr;
    logic [1:0]        failedStage;
    logic [15:0]       lastRunCycles;
    logic [1:0]        dbgState;
    logic [1:0]        dbgStage;

    modport master (
        output start, testMuxSel, testReadAddr, testWriteAddr, testMemOut, testMemWriteEn,
        output s0Done, s1Done, s2Done,
        output s0ReadAddr, s1ReadAddr, s2ReadAddr,
        output s0WriteAddr, s1WriteAddr, s2WriteAddr,
        output s0MemOut, s1MemOut, s2MemOut,
        output s0WriteEn, s1WriteEn, s2WriteEn,
        input  s0Start, s1Start, s2Start,
        input  memReadAddr, memWriteAddr, memOut, memWriteEn,
        input  busy, done, timeoutErr, failedStage, lastRunCycles,
        input  dbgState, dbgStage
    );

    modport slave (
        input  start, testMuxSel, testReadAddr, testWriteAddr, testMemOut, testMemWriteEn,
        input  s0Done, s1Done, s2Done,
        input  s0ReadAddr, s1ReadAddr, s2ReadAddr,
        input  s0WriteAddr, s1WriteAddr, s2WriteAddr,
        input  s0MemOut, s1MemOut, s2MemOut,
        input  s0WriteEn, s1WriteEn, s2WriteEn,
        output s0Start, s1Start, s2Start,
        output memReadAddr, memWriteAddr, memOut, memWriteEn,
        output busy, done, timeoutErr, failedStage, lastRunCycles,
        output dbgState, dbgStage
    );
endinterface

// File: rtl/acelp_codebook_sequencer.sv
// ---------------------------------------------------------------------------
// acelp_codebook_sequencer
//
// Purpose: top-level controller of the ACELP fixed-codebook search. It runs
// three stages in a fixed order: Cor_hPipe, then Cor_h_X, then the D4i40_17
// search. Each stage gets a one-cycle start pulse, and the sequencer then
// waits for that stage's done level. A per-stage watchdog aborts a stage
// that hangs. The module also owns the single scratch-memory port. That
// port belongs to the active stage during a run. When idle it belongs to
// the test port if testMuxSel=1.
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high
//   bus    - acelp_codebook_sequencer_if.slave (all other signals)
//
// Parameters:
//   ADDR_W         - scratch memory address width
//   DATA_W         - scratch memory data width
//   TIMEOUT_CYCLES - max cycles per stage, counted from its start pulse (2..65535)
//
// Optional feature (macro ACELP_SEQ_PERF_EN): when defined, lastRunCycles
// reports the number of busy cycles of the last finished run, saturating
// at 0xFFFF. When undefined, lastRunCycles is tied to 0.
// ---------------------------------------------------------------------------
module acelp_codebook_sequencer #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input logic                        clk,
    input logic                        reset,
    acelp_codebook_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PULSE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // The cycle counter reads 0 in the PULSE cycle and counts up through
    // WAIT. A count of TIMEOUT_CYCLES-1 is therefore the last cycle a stage
    // may report done.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [1:0]  r_stage;
    logic [1:0]  w_stage_nxt;
    logic [15:0] r_cnt;
    logic        r_timeout_err;
    logic [1:0]  r_failed_stage;

    logic        w_busy;
    logic        w_accept;
    logic        w_cur_done;
    logic        w_timeout;

    // Done level of the active stage only. Other stages' done levels are
    // never looked at.
    always_comb begin
        w_cur_done = 1'b0;
        case (r_stage)
            2'd0:    w_cur_done = bus.s0Done;
            2'd1:    w_cur_done = bus.s1Done;
            2'd2:    w_cur_done = bus.s2Done;
            default: w_cur_done = 1'b0;
        endcase
    end

    assign w_busy    = (r_state == ST_PULSE) || (r_state == ST_WAIT);
    // While testMuxSel=1 the test port may own memory, so a run is refused.
    assign w_accept  = ((r_state == ST_IDLE) || (r_state == ST_FINISH)) &&
                       bus.start && !bus.testMuxSel;
    // Done wins over timeout when both land in the same cycle.
    assign w_timeout = (r_state == ST_WAIT) && !w_cur_done && (r_cnt == TMO_LAST);

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_stage <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_stage <= w_stage_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_state_nxt = r_state;
        w_stage_nxt = r_stage;
        case (r_state)
            ST_IDLE, ST_FINISH: begin
                if (w_accept) begin
                    w_state_nxt = ST_PULSE;
                    w_stage_nxt = 2'd0;
                end
            end
            // Done is not sampled here, so a stale done from the last run
            // cannot skip a stage.
            ST_PULSE: w_state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (w_cur_done) begin
                    if (r_stage == 2'd2) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_state_nxt = ST_PULSE;
                        w_stage_nxt = r_stage + 2'd1;
                    end
                end else if (w_timeout) begin
                    w_state_nxt = ST_FINISH;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- per-stage cycle counter ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 16'd0;
        end else if (w_state_nxt == ST_PULSE) begin
            r_cnt <= 16'd0;
        end else if (w_busy) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // ---------------- abort status ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timeout_err  <= 1'b0;
            r_failed_stage <= 2'd0;
        end else if (w_accept) begin
            r_timeout_err  <= 1'b0;
            r_failed_stage <= 2'd0;
        end else if (w_timeout) begin
            r_timeout_err  <= 1'b1;
            r_failed_stage <= r_stage;
        end
    end

    // ---------------- FSM: outputs and memory mux ----------------
    always_comb begin
        bus.s0Start      = (r_state == ST_PULSE) && (r_stage == 2'd0);
        bus.s1Start      = (r_state == ST_PULSE) && (r_stage == 2'd1);
        bus.s2Start      = (r_state == ST_PULSE) && (r_stage == 2'd2);
        bus.busy         = w_busy;
        bus.done         = (r_state == ST_FINISH);
        bus.timeoutErr   = r_timeout_err;
        bus.failedStage  = r_failed_stage;
        bus.dbgState     = r_state;
        bus.dbgStage     = r_stage;

        bus.memReadAddr  = {ADDR_W{1'b0}};
        bus.memWriteAddr = {ADDR_W{1'b0}};
        bus.memOut       = {DATA_W{1'b0}};
        bus.memWriteEn   = 1'b0;
        // Owner comes from registered state only. testMuxSel cannot steal
        // the port mid-run.
        if (w_busy) begin
            case (r_stage)
                2'd0: begin
                    bus.memReadAddr  = bus.s0ReadAddr;
                    bus.memWriteAddr = bus.s0WriteAddr;
                    bus.memOut       = bus.s0MemOut;
                    bus.memWriteEn   = bus.s0WriteEn;
                end
                2'd1: begin
                    bus.memReadAddr  = bus.s1ReadAddr;
                    bus.memWriteAddr = bus.s1WriteAddr;
                    bus.memOut       = bus.s1MemOut;
                    bus.memWriteEn   = bus.s1WriteEn;
                end
                2'd2: begin
                    bus.memReadAddr  = bus.s2ReadAddr;
                    bus.memWriteAddr = bus.s2WriteAddr;
                    bus.memOut       = bus.s2MemOut;
                    bus.memWriteEn   = bus.s2WriteEn;
                end
                default: ;
            endcase
        end else if (bus.testMuxSel) begin
            bus.memReadAddr  = bus.testReadAddr;
            bus.memWriteAddr = bus.testWriteAddr;
            bus.memOut       = bus.testMemOut;
            bus.memWriteEn   = bus.testMemWriteEn;
        end
    end

`ifdef ACELP_SEQ_PERF_EN
    logic [15:0] r_perf_cnt;
    logic [15:0] r_last_cycles;
    logic [15:0] w_perf_inc;

    // Saturating increment. The snapshot taken on FINISH entry includes
    // the final busy cycle, so it equals the run's busy-cycle count.
    assign w_perf_inc = (r_perf_cnt == 16'hFFFF) ? r_perf_cnt : r_perf_cnt + 16'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cnt    <= 16'd0;
            r_last_cycles <= 16'd0;
        end else begin
            if (w_accept) begin
                r_perf_cnt <= 16'd0;
            end else if (w_busy) begin
                r_perf_cnt <= w_perf_inc;
            end
            if (w_busy && (w_state_nxt == ST_FINISH)) begin
                r_last_cycles <= w_perf_inc;
            end
        end
    end

    assign bus.lastRunCycles = r_last_cycles;
`else
    assign bus.lastRunCycles = 16'd0;
`endif

endmodule

// File: tb/tb_acelp_codebook_sequencer.sv
// ---------------------------------------------------------------------------
// tb_acelp_codebook_sequencer
//
// Self-checking bench for acelp_codebook_sequencer. The stages are emulated
// by responders with a chosen done latency. A latency beyond the timeout
// means the stage hangs. The expected timeline of each run comes from a
// plain-arithmetic model of the run rules:
//   - stage pulses;
//   - finish cycle;
//   - abort status;
//   - busy-cycle count.
// The expected memory owner in each cycle is derived from that timeline.
// ---------------------------------------------------------------------------
module tb_acelp_codebook_sequencer;

    localparam int ADDR_W = 11;
    localparam int DATA_W = 32;
    localparam int TMO    = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    acelp_codebook_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    acelp_codebook_sequencer #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // ---------------- bench state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    int lat[3];
    int k_cnt[3];
    int exp_pulse[3];
    int exp_npulse;
    int exp_fin;
    int exp_fstage;
    int exp_last;
    bit exp_terr;
    logic [31:0] exp_q[$];

    logic [ADDR_W-1:0] s_raddr[3];
    logic [ADDR_W-1:0] s_waddr[3];
    logic [DATA_W-1:0] s_wdata[3];
    logic              s_we[3];
    logic              s_done[3];
    logic [ADDR_W-1:0] t_raddr, t_waddr;
    logic [DATA_W-1:0] t_wdata;
    logic              t_we, t_sel;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply();
        bus.s0Done = s_done[0]; bus.s1Done = s_done[1]; bus.s2Done = s_done[2];
        bus.s0ReadAddr = s_raddr[0]; bus.s1ReadAddr = s_raddr[1]; bus.s2ReadAddr = s_raddr[2];
        bus.s0WriteAddr = s_waddr[0]; bus.s1WriteAddr = s_waddr[1]; bus.s2WriteAddr = s_waddr[2];
        bus.s0MemOut = s_wdata[0]; bus.s1MemOut = s_wdata[1]; bus.s2MemOut = s_wdata[2];
        bus.s0WriteEn = s_we[0]; bus.s1WriteEn = s_we[1]; bus.s2WriteEn = s_we[2];
        bus.testReadAddr = t_raddr;
        bus.testWriteAddr = t_waddr;
        bus.testMemOut = t_wdata;
        bus.testMemWriteEn = t_we;
        bus.testMuxSel = t_sel;
    endtask

    task automatic rand_mem();
        for (int n = 0; n < 3; n++) begin
            s_raddr[n] = ADDR_W'($urandom);
            s_waddr[n] = ADDR_W'($urandom);
            s_wdata[n] = DATA_W'($urandom);
            s_we[n]    = 1'($urandom_range(0, 1));
        end
        t_raddr = ADDR_W'($urandom);
        t_waddr = ADDR_W'($urandom);
        t_wdata = DATA_W'($urandom);
        t_we    = 1'($urandom_range(0, 1));
    endtask

    function automatic logic start_bit(input int n);
        case (n)
            0:       return bus.s0Start;
            1:       return bus.s1Start;
            default: return bus.s2Start;
        endcase
    endfunction

    function automatic logic [63:0] got_mem();
        return {9'd0, bus.memReadAddr, bus.memWriteAddr, bus.memOut, bus.memWriteEn};
    endfunction

    function automatic logic [63:0] got_ctl();
        return 64'({bus.s0Start, bus.s1Start, bus.s2Start, bus.busy, bus.done,
                    bus.timeoutErr, bus.failedStage, bus.lastRunCycles, bus.dbgState});
    endfunction

    // ---------------- reference model ----------------
    // Stage n pulses at p. A done latency L <= TMO-1 hands over to the next
    // stage at p+L+1 (or finishes there after stage 2). Otherwise the run
    // aborts at p+TMO.
    task automatic predict();
        int  p = 0;
        bit  stopped = 0;
        exp_npulse = 0;
        exp_terr   = 0;
        exp_fstage = 0;
        exp_fin    = 0;
        for (int n = 0; n < 3; n++) begin
            if (!stopped) begin
                exp_pulse[n] = p;
                exp_npulse   = n + 1;
                if (lat[n] <= TMO - 1) begin
                    p       = p + lat[n] + 1;
                    exp_fin = p;
                end else begin
                    exp_fin    = p + TMO;
                    exp_terr   = 1;
                    exp_fstage = n;
                    stopped    = 1;
                end
            end
        end
`ifdef ACELP_SEQ_PERF_EN
        exp_last = (exp_fin > 65535) ? 65535 : exp_fin;
`else
        exp_last = 0;
`endif
    endtask

    // Stage owning memory rel cycles after the accepted start (-1 = none).
    function automatic int owner_at(input int rel);
        int o = -1;
        if (rel < exp_fin)
            for (int n = 0; n < exp_npulse; n++)
                if (exp_pulse[n] <= rel) o = n;
        return o;
    endfunction

    function automatic logic [63:0] exp_mem(input int owner, input logic sel);
        if (owner >= 0)
            return {9'd0, s_raddr[owner], s_waddr[owner], s_wdata[owner], s_we[owner]};
        if (sel)
            return {9'd0, t_raddr, t_waddr, t_wdata, t_we};
        return 64'd0;
    endfunction

    // ---------------- run driver + scoreboard ----------------
    task automatic run_case(input int l0, input int l1, input int l2,
                            input bit rst_mid, input bit directed);
        int          rel;
        bit          fin_loop;
        logic [31:0] obs;
        lat[0] = l0; lat[1] = l1; lat[2] = l2;
        predict();
        exp_q.delete();
        for (int n = 0; n < exp_npulse; n++)
            exp_q.push_back({16'(n), 16'(exp_pulse[n])});
        for (int n = 0; n < 3; n++) k_cnt[n] = -1;

        t_sel = 1'b0;
        apply();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        rel = 0;
        fin_loop = 0;
        while (!fin_loop) begin
            check("status", 64'({bus.busy, bus.done}),
                  64'({rel < exp_fin, rel >= exp_fin}));
            for (int n = 0; n < 3; n++) begin
                if (start_bit(n)) begin
                    obs = {16'(n), 16'(rel)};
                    if (exp_q.size() > 0) check("pulse", 64'(obs), 64'(exp_q.pop_front()));
                    else check("pulse_extra", 64'(obs), 64'hFFFF_FFFF);
                end
            end
            if (rel >= exp_fin) begin
                bus.start = 1'b0;
                check("timeout_err", 64'(bus.timeoutErr), 64'(exp_terr));
                check("failed_stage", 64'(bus.failedStage), 64'(exp_terr ? exp_fstage : 0));
                check("last_cycles", 64'(bus.lastRunCycles), 64'(exp_last));
                check("pulse_missing", 64'(exp_q.size()), 64'd0);
                fin_loop = 1;
            end else if (rst_mid && rel == exp_pulse[2] + 2) begin
                reset = 1'b1;
                bus.start = 1'b0;
                t_sel = 1'b0;
                apply();
                tick();
                check("reset_ctl", got_ctl(), 64'd0);
                check("reset_mem", got_mem(), 64'd0);
                reset = 1'b0;
                fin_loop = 1;
            end else begin
                // Stage responders: done stays stale through the pulse cycle,
                // then reflects the latency counted from the pulse.
                for (int n = 0; n < 3; n++) begin
                    if (start_bit(n)) k_cnt[n] = 0;
                    else if (k_cnt[n] >= 0) begin
                        k_cnt[n]++;
                        s_done[n] = (k_cnt[n] >= lat[n]);
                    end
                end
                rand_mem();
                bus.start = ($urandom_range(0, 7) == 0);
                t_sel = 1'($urandom_range(0, 1));
                if (directed && owner_at(rel) == 1) begin
                    s_waddr[1] = 11'h2A5;
                    s_we[1]    = 1'b1;
                    s_we[0]    = 1'b1;
                    t_we       = 1'b1;
                    t_sel      = 1'b1;
                end
                apply();
                #1;
                check("mem", got_mem(), exp_mem(owner_at(rel), t_sel));
                if (directed && owner_at(rel) == 1)
                    check("own_waddr", 64'(bus.memWriteAddr), 64'h2A5);
                tick();
                rel++;
            end
        end
    endtask

    // Start requests while testMuxSel=1 and idle must be ignored. The
    // memory port goes to the test port.
    task automatic idle_cycles(input int n, input logic exp_done);
        for (int i = 0; i < n; i++) begin
            rand_mem();
            t_sel = 1'b1;
            apply();
            bus.start = 1'b1;
            #1;
            check("idle_mem", got_mem(), exp_mem(-1, 1'b1));
            tick();
            check("idle_status",
                  64'({bus.s0Start, bus.s1Start, bus.s2Start, bus.busy, bus.done}),
                  64'({4'b0000, exp_done}));
        end
        bus.start = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int n = 0; n < 3; n++) begin
            s_raddr[n] = '0; s_waddr[n] = '0; s_wdata[n] = '0;
            s_we[n] = 1'b0; s_done[n] = 1'b0;
        end
        t_raddr = '0; t_waddr = '0; t_wdata = '0; t_we = 1'b0; t_sel = 1'b0;
        bus.start = 1'b0;
        apply();
        reset = 1'b1;
        repeat (3) tick();
        check("reset_ctl", got_ctl(), 64'd0);
        check("reset_mem", got_mem(), 64'd0);
        reset = 1'b0;
        tick();

        // Normal run with directed ownership during stage 1.
        run_case(10, 5, 7, 1'b0, 1'b1);
        // Test port after FINISH.
        t_sel = 1'b1; t_waddr = 11'h5C3; t_we = 1'b1;
        apply();
        #1;
        check("test_waddr", 64'(bus.memWriteAddr), 64'h5C3);
        check("test_we", 64'(bus.memWriteEn), 64'd1);
        idle_cycles(3, 1'b1);

        // Watchdog on stage 1; stage 2 must never start.
        run_case(3, 1000, 4, 1'b0, 1'b0);
        // Done on the last allowed cycle beats the timeout; stage 2 one cycle late.
        run_case(TMO - 1, 2, TMO, 1'b0, 1'b0);
        // Stage 0 hangs.
        run_case(1000, 1, 1, 1'b0, 1'b0);
        // Minimum latencies, stale done from previous runs.
        run_case(1, 1, 1, 1'b0, 1'b0);

        // Reset during stage 2 WAIT, then a fresh run starting at stage 0.
        run_case(4, 4, 12, 1'b1, 1'b0);
        idle_cycles(2, 1'b0);
        run_case(6, 2, 3, 1'b0, 1'b0);

        // Randomized runs, latencies straddling the timeout.
        for (int r = 0; r < 25; r++)
            run_case(int'($urandom_range(1, TMO + 2)), int'($urandom_range(1, TMO + 2)),
                     int'($urandom_range(1, TMO + 2)), 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
